// File: rtl/lcb_pkg.sv
// lcb_pkg: shared state encodings and frame constants for the LCB responder.
package lcb_pkg;
  typedef enum logic [2:0] {IDLE, RXPKT, GAP, GUARD_PRE, TXBYTE, GUARD_POST} lcbState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  localparam logic [7:0] DEF_MY_ADDR = 8'h5A;
  localparam int START_BITS = 1;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;
endpackage

// File: rtl/lcb_rx_byte.sv
// lcb_rx_byte: 8N1 receiver with synchroniser, glitch-rejecting start detect and mid-bit sampling.
module lcb_rx_byte
  import lcb_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       enable,
  output logic [7:0] rxByte,
  output logic       byteValid,
  output logic       frameErr
);
  localparam logic [15:0] HALF = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL = 16'(BAUD_DIV - 1);
  rxState_t state, nextState;
  logic [2:0] sync;
  logic [15:0] cnt;
  logic [2:0] bitCnt;
  logic rxs, tick;
  assign rxs = sync[1];
  assign tick = cnt == (state == RX_START ? HALF : FULL);
  always_comb begin
    nextState = state;
    if (!enable) nextState = RX_IDLE;
    else case (state)
      RX_IDLE:  nextState = (sync[2] && !rxs) ? RX_START : RX_IDLE;
      RX_START: nextState = !tick ? RX_START : rxs ? RX_IDLE : RX_DATA;
      RX_DATA:  nextState = (tick && bitCnt == 3'(DATA_BITS - 1)) ? RX_STOP : RX_DATA;
      RX_STOP:  nextState = tick ? RX_IDLE : RX_STOP;
      default:  nextState = RX_IDLE;
    endcase
  end
  // sync[1:0] is the synchroniser, sync[2] the previous sample for edge detect
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RX_IDLE;
      sync <= '1;
      cnt <= '0;
      bitCnt <= '0;
      rxByte <= '0;
      byteValid <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      state <= nextState;
      sync <= {sync[1:0], rx};
      cnt <= (state == RX_IDLE || tick) ? 16'd0 : cnt + 16'd1;
      bitCnt <= state != RX_DATA ? 3'd0 : bitCnt + 3'(tick);
      if (state == RX_DATA && tick) rxByte <= {rxs, rxByte[7:1]};
      byteValid <= enable && state == RX_STOP && tick && rxs;
      frameErr <= enable && state == RX_STOP && tick && !rxs;
    end
endmodule

// File: rtl/lcb_responder.sv
// lcb_responder: LCB end of the RS485 request/response link; answers matching
// requests with a fixed-length response read from external synchronous memory.
module lcb_responder
  import lcb_pkg::*;
#(
  parameter int         BAUD_DIV     = 16,
  parameter int         REQ_BYTES    = 4,
  parameter int         RESP_BYTES   = 16,
  parameter logic [7:0] MY_ADDR      = DEF_MY_ADDR,
  parameter int         GAP_BITS     = 4,
  parameter int         GUARD_BITS   = 1,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [8:0] rdAddr,
  input  logic [7:0] rdData,
  output logic       tx,
  output logic       dirTX,
  output logic       dirRX,
  output logic [7:0] oCmd,
  output logic       oReqStrob,
  output logic       busy,
  output logic [7:0] errCnt
);
  localparam logic [15:0] BIT_END = 16'(BAUD_DIV - 1);
  localparam logic [15:0] GAP_END = 16'(GAP_BITS * BAUD_DIV - 1);
  localparam logic [15:0] GUARD_END = 16'(GUARD_BITS * BAUD_DIV - 1);
  localparam logic [15:0] TIMEOUT_END = 16'(TIMEOUT_BITS * BAUD_DIV - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);
  localparam logic [3:0] LAST_DATA = 4'(START_BITS + DATA_BITS - 1);
  localparam logic [4:0] LAST_IDX = 5'(RESP_BYTES - 1);
  localparam logic [3:0] LAST_REQ = 4'(REQ_BYTES - 1);
  lcbState_t state, nextState;
  logic [15:0] tmr;
  logic [3:0] bitNum, nBytes;
  logic [4:0] idx;
  logic [7:0] dataSr, addrByte, cmdByte, rxByte;
  logic byteValid, frameErr, tmrEnd, lastByte, accept, errInc;
  lcb_rx_byte #(.BAUD_DIV(BAUD_DIV)) uRx (
    .clk(clk), .rst(rst), .rx(rx), .enable(!dirTX && !busy),
    .rxByte(rxByte), .byteValid(byteValid), .frameErr(frameErr)
  );
  assign rdAddr = {oCmd[4:0], idx[3:0]};
  assign dirRX = dirTX;
  assign tmrEnd = tmr == (state == GAP ? GAP_END :
                          state == RXPKT ? TIMEOUT_END :
                          (state == GUARD_PRE || state == GUARD_POST) ? GUARD_END : BIT_END);
  assign lastByte = nBytes == LAST_REQ;
  assign accept = state == RXPKT && byteValid && lastByte && addrByte == MY_ADDR;
  assign errInc = frameErr || (state == RXPKT && !byteValid && tmrEnd);
  always_comb begin
    nextState = state;
    case (state)
      IDLE:       nextState = byteValid ? RXPKT : IDLE;
      RXPKT:      nextState = frameErr ? IDLE :
                              byteValid ? (!lastByte ? RXPKT : addrByte == MY_ADDR ? GAP : IDLE) :
                              tmrEnd ? IDLE : RXPKT;
      GAP:        nextState = tmrEnd ? GUARD_PRE : GAP;
      GUARD_PRE:  nextState = tmrEnd ? TXBYTE : GUARD_PRE;
      TXBYTE:     nextState = (tmrEnd && bitNum == LAST_BIT && idx == LAST_IDX) ? GUARD_POST : TXBYTE;
      GUARD_POST: nextState = tmrEnd ? IDLE : GUARD_POST;
      default:    nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tmr <= '0;
      bitNum <= '0;
      nBytes <= '0;
      idx <= '0;
      dataSr <= '0;
      addrByte <= '0;
      cmdByte <= '0;
      tx <= 1'b1;
      dirTX <= 1'b0;
      oCmd <= '0;
      oReqStrob <= 1'b0;
      busy <= 1'b0;
      errCnt <= '0;
    end else begin
      state <= nextState;
      oReqStrob <= accept;
      tmr <= (state == IDLE || state != nextState || tmrEnd || byteValid) ? 16'd0 : tmr + 16'd1;
      if (errInc && errCnt != 8'hFF) errCnt <= errCnt + 8'd1;
      if (byteValid) begin
        nBytes <= state == IDLE ? 4'd1 : nBytes + 4'd1;
        if (state == IDLE) addrByte <= rxByte;
        if (state == RXPKT && nBytes == 4'd1) cmdByte <= rxByte;
      end
      if (accept) begin
        oCmd <= nBytes == 4'd1 ? rxByte : cmdByte;
        busy <= 1'b1;
      end
      if (state == GAP && tmrEnd) begin
        dirTX <= 1'b1;
        idx <= '0;
      end
      if (state == GUARD_PRE && tmrEnd) begin
        tx <= 1'b0;
        bitNum <= '0;
      end
      // idx advances at the start bit; memory data is taken one clk later, before the first data bit
      if (state == TXBYTE) begin
        if (bitNum == 4'd0 && tmr == 16'd1) dataSr <= rdData;
        if (tmrEnd) begin
          bitNum <= bitNum == LAST_BIT ? 4'd0 : bitNum + 4'd1;
          tx <= bitNum == LAST_BIT ? idx == LAST_IDX : bitNum == LAST_DATA ? 1'b1 : dataSr[0];
          if (bitNum < LAST_DATA) dataSr <= dataSr >> 1;
          if (bitNum == LAST_BIT) idx <= idx + 5'd1;
        end
      end
      if (state == GUARD_POST && tmrEnd) begin
        dirTX <= 1'b0;
        busy <= 1'b0;
      end
    end
endmodule

// File: tb/tb_lcb_responder.sv
`timescale 1ns/1ps
// tb_lcb_responder: drives request packets and checks responses against a packet-level model.
module tb_lcb_responder;
  localparam int BAUD = 16;
  localparam int RESP = 16;
  localparam logic [7:0] MY = 8'h5A;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [8:0] rdAddr;
  logic [7:0] rdData = 8'h00;
  logic tx, dirTX, dirRX, oReqStrob, busy;
  logic [7:0] oCmd, errCnt;
  logic [7:0] mem [512];
  int passCnt = 0, checkCnt = 0, cyc = 0, expErr = 0;
  int strobeCnt = 0, strobeCyc = 0, dirRiseCnt = 0, dirRiseCyc = 0;
  int dirFallCnt = 0, dirFallCyc = 0, busyFallCyc = 0, dirRxBad = 0;
  logic dirPrev = 1'b0, busyPrev = 1'b0, busyAtRise = 1'b0;
  logic [7:0] gotBytes[$];
  int gotStart[$];
  bit gotFrameOk[$];
  int monS;
  logic [7:0] monD, ra;
  bit monOk;

  lcb_responder dut (
    .clk(clk), .rst(rst), .rx(rx), .rdAddr(rdAddr), .rdData(rdData), .tx(tx),
    .dirTX(dirTX), .dirRX(dirRX), .oCmd(oCmd), .oReqStrob(oReqStrob), .busy(busy), .errCnt(errCnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rdData <= mem[rdAddr];
  end

  always @(negedge clk) begin
    if (oReqStrob) begin
      strobeCnt <= strobeCnt + 1;
      strobeCyc <= cyc;
    end
    if (dirTX && !dirPrev) begin
      dirRiseCnt <= dirRiseCnt + 1;
      dirRiseCyc <= cyc;
      busyAtRise <= busy;
    end
    if (!dirTX && dirPrev) begin
      dirFallCnt <= dirFallCnt + 1;
      dirFallCyc <= cyc;
    end
    if (!busy && busyPrev) busyFallCyc <= cyc;
    if (dirRX !== dirTX) dirRxBad <= dirRxBad + 1;
    dirPrev <= dirTX;
    busyPrev <= busy;
  end

  // UART decoder on tx while the driver is enabled
  initial forever begin
    @(negedge clk);
    if (dirTX && !tx) begin
      monS = cyc;
      repeat (BAUD / 2) @(negedge clk);
      monOk = !tx;
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD) @(negedge clk);
        monD[i] = tx;
      end
      repeat (BAUD) @(negedge clk);
      monOk = monOk && tx;
      gotBytes.push_back(monD);
      gotStart.push_back(monS);
      gotFrameOk.push_back(monOk);
      repeat (BAUD / 2 - 1) @(negedge clk);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkCnt++;
    if (got === want) passCnt++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, want, want);
  endtask

  task automatic sendBits(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    sendBits(1'b0, BAUD);
    for (int i = 0; i < 8; i++) sendBits(b[i], BAUD);
    sendBits(stopBit, BAUD);
    rx = 1'b1;
  endtask

  task automatic sendReq(input logic [7:0] a, input logic [7:0] c, input logic [7:0] d2, input logic [7:0] d3);
    sendByte(a, 1'b1);
    sendByte(c, 1'b1);
    sendByte(d2, 1'b1);
    sendByte(d3, 1'b1);
  endtask

  task automatic quiet(input string tag, input int s0, input int r0);
    repeat (1500) @(negedge clk);
    chk({tag, "_strobe"}, strobeCnt - s0, 0);
    chk({tag, "_dirTX"}, dirRiseCnt - r0, 0);
  endtask

  // Model: a request is answered iff its address matches; the response is
  // RESP bytes read from memory at {cmd[4:0], index}, framed with fixed gaps.
  task automatic runReq(input logic [7:0] a, input logic [7:0] c, input logic [7:0] d2, input logic [7:0] d3);
    int b0, s0, f0, r0, n, last;
    b0 = gotBytes.size();
    s0 = strobeCnt;
    f0 = dirFallCnt;
    r0 = dirRiseCnt;
    sendReq(a, c, d2, d3);
    if (a != MY) begin
      quiet("mismatch", s0, r0);
    end else begin
      for (int i = 0; i < 6000 && dirFallCnt == f0; i++) @(negedge clk);
      @(negedge clk);
      chk("respDone", dirFallCnt - f0, 1);
      chk("strobeCnt", strobeCnt - s0, 1);
      chk("oCmd", oCmd, c);
      chk("gapClks", dirRiseCyc - strobeCyc, 64);
      chk("busyAtRise", busyAtRise, 1);
      n = gotBytes.size() - b0;
      chk("respBytes", n, RESP);
      if (n == RESP) begin
        for (int i = 0; i < RESP; i++) begin
          chk($sformatf("byte%0d", i), gotBytes[b0 + i], mem[{c[4:0], i[3:0]}]);
          chk($sformatf("frame%0d", i), gotFrameOk[b0 + i], 1);
          if (i == 0) chk("guardPre", gotStart[b0] - dirRiseCyc, BAUD);
          else chk($sformatf("spacing%0d", i), gotStart[b0 + i] - gotStart[b0 + i - 1], 10 * BAUD);
        end
        last = gotStart[b0 + RESP - 1];
        chk("guardPost", dirFallCyc - (last + 10 * BAUD), BAUD);
      end
      chk("busyFall", (busyFallCyc - dirFallCyc) inside {0, 1}, 1);
    end
  endtask

  initial begin
    int b0, s0, r0;
    for (int a = 0; a < 512; a++) mem[a] = 8'(a);
    repeat (4) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_dirTX", dirTX, 0);
    chk("rst_dirRX", dirRX, 0);
    chk("rst_rdAddr", rdAddr, 0);
    chk("rst_oCmd", oCmd, 0);
    chk("rst_strobe", oReqStrob, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errCnt", errCnt, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    runReq(MY, 8'h03, 8'h00, 8'h00);
    for (int a = 0; a < 512; a++) mem[a] = 8'($urandom);

    runReq(8'h11, 8'h03, 8'h00, 8'h00);
    chk("mismatch_err", errCnt, expErr);

    s0 = strobeCnt; r0 = dirRiseCnt;
    sendByte(MY, 1'b1);
    sendByte(8'h03, 1'b1);
    sendByte(8'h00, 1'b0);
    sendBits(1'b1, 4 * BAUD);
    expErr++;
    chk("frameErr", errCnt, expErr);
    quiet("frameErr", s0, r0);
    runReq(MY, 8'($urandom), 8'($urandom), 8'($urandom));

    s0 = strobeCnt; r0 = dirRiseCnt;
    sendByte(MY, 1'b1);
    sendByte(8'h03, 1'b1);
    sendBits(1'b1, 21 * BAUD);
    sendByte(8'h00, 1'b1);
    sendByte(8'h00, 1'b1);
    expErr++;
    chk("timeoutErr", errCnt, expErr);
    sendByte(8'h00, 1'b1);
    sendByte(8'h00, 1'b1);
    quiet("timeout", s0, r0);
    chk("timeoutErrAfter", errCnt, expErr);

    s0 = strobeCnt; r0 = dirRiseCnt;
    sendBits(1'b0, 5);
    sendBits(1'b1, 40 * BAUD);
    chk("glitchErr", errCnt, expErr);
    quiet("glitch", s0, r0);
    runReq(MY, 8'($urandom), 8'($urandom), 8'($urandom));

    for (int n = 0; n < 6; n++) begin
      ra = $urandom_range(0, 1) ? MY : 8'($urandom);
      runReq(ra, 8'($urandom), 8'($urandom), 8'($urandom));
    end
    chk("randomErr", errCnt, expErr);

    b0 = gotBytes.size();
    sendReq(MY, 8'($urandom), 8'h00, 8'h00);
    for (int i = 0; i < 4000 && gotBytes.size() < b0 + 5; i++) @(negedge clk);
    chk("reachByte5", gotBytes.size() >= b0 + 5, 1);
    repeat (BAUD / 2 + 4) @(negedge clk);
    chk("preRst_tx", tx, 0);
    rst = 1'b1;
    #1;
    chk("midRst_tx", tx, 1);
    chk("midRst_dirTX", dirTX, 0);
    chk("midRst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expErr = 0;
    repeat (300) @(negedge clk);
    chk("postRst_err", errCnt, expErr);
    runReq(MY, 8'($urandom), 8'($urandom), 8'($urandom));

    chk("dirRX_eq_dirTX", dirRxBad, 0);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
